// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and address-decode results.
package apb_pkg;
    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    typedef enum logic [1:0] {
        DEC_RW  = 2'd0,
        DEC_RO  = 2'd1,
        DEC_ERR = 2'd2
    } apb_dec_e;

    // Merge write data into an existing word, one byte lane per strobe bit.
    function automatic logic [APB_DATA_W-1:0] apply_strb(
        input logic [APB_DATA_W-1:0] old_val,
        input logic [APB_DATA_W-1:0] wdata,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] v;
        v = old_val;
        for (int k = 0; k < APB_STRB_W; k++) begin
            if (strb[k]) begin
                v[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return v;
    endfunction
endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: classifies a byte address as RW register, RO status or error.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 8,
    parameter logic [APB_ADDR_W-1:0] STATUS_ADDR = 12'h100,
    parameter int                    IDX_W       = 3
) (
    input  logic [APB_ADDR_W-1:0] i_paddr,
    input  logic                  i_pwrite,
    output logic [1:0]            o_dec,
    output logic [IDX_W-1:0]      o_idx
);
    localparam logic [APB_ADDR_W-3:0] LP_NUM_WORDS = (APB_ADDR_W-2)'(NUM_REGS);

    logic [APB_ADDR_W-3:0] w_word;
    logic                  w_aligned;

    assign w_word    = i_paddr[APB_ADDR_W-1:2];
    assign w_aligned = (i_paddr[1:0] == 2'b00);
    assign o_idx     = w_word[IDX_W-1:0];

    // The status word is read-only; a write to it is an error, not a silent drop.
    always_comb begin
        o_dec = DEC_ERR;
        if (i_paddr == STATUS_ADDR) begin
            o_dec = i_pwrite ? DEC_ERR : DEC_RO;
        end else if (w_aligned && (w_word < LP_NUM_WORDS)) begin
            o_dec = DEC_RW;
        end
    end
endmodule

// File: rtl/apb_reg_responder.sv
// APB completer with NUM_REGS byte-strobed RW registers, one RO status word,
// fixed wait-state insertion and error response on illegal accesses.
module apb_reg_responder
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [APB_ADDR_W-1:0] STATUS_ADDR = 12'h100
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [APB_ADDR_W-1:0]    paddr,
    input  logic [APB_STRB_W-1:0]    pstrb,
    input  logic [APB_DATA_W-1:0]    pwdata,
    output logic                     pready,
    output logic                     pslverr,
    output logic [APB_DATA_W-1:0]    prdata,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse,
    input  logic [APB_DATA_W-1:0]    status_i,
    output logic                     o_dbg_state
);
    localparam int         IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    apb_state_e            r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [APB_STRB_W-1:0] r_strb;
    logic [APB_DATA_W-1:0] r_wdata;
    apb_dec_e              r_dec;
    logic [IDX_W-1:0]      r_idx;
    logic [APB_DATA_W-1:0] r_rdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [APB_DATA_W-1:0] r_prdata;
    logic [APB_DATA_W-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic [1:0]            w_dec_raw;
    apb_dec_e              w_dec;
    logic [IDX_W-1:0]      w_idx;
    logic [APB_DATA_W-1:0] w_rdata;
    logic                  w_setup;

    apb_addr_decode #(
        .NUM_REGS    (NUM_REGS),
        .STATUS_ADDR (STATUS_ADDR),
        .IDX_W       (IDX_W)
    ) u_decode (
        .i_paddr  (paddr),
        .i_pwrite (pwrite),
        .o_dec    (w_dec_raw),
        .o_idx    (w_idx)
    );

    assign w_dec   = apb_dec_e'(w_dec_raw);
    assign w_setup = psel & ~penable;

    // Read data is sampled at the setup edge; writes and errors carry zero.
    always_comb begin
        w_rdata = '0;
        if (!pwrite) begin
            if (w_dec == DEC_RO) begin
                w_rdata = status_i;
            end else if (w_dec == DEC_RW) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_idx == IDX_W'(i)) begin
                        w_rdata = r_regs[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_strb     <= '0;
            r_wdata    <= '0;
            r_dec      <= DEC_ERR;
            r_idx      <= '0;
            r_rdata    <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pulse <= '0;
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_state <= ACCESS;
                        r_cnt   <= LP_WAIT;
                        r_write <= pwrite;
                        r_strb  <= pstrb;
                        r_wdata <= pwdata;
                        r_dec   <= w_dec;
                        r_idx   <= w_idx;
                        r_rdata <= w_rdata;
                        // With no wait states the first access cycle already completes.
                        if (LP_WAIT == 4'd0) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= (w_dec == DEC_ERR);
                            r_prdata  <= w_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                    end else if (r_cnt == 4'd0) begin
                        if (penable) begin
                            r_state   <= IDLE;
                            r_pready  <= 1'b0;
                            r_pslverr <= 1'b0;
                            r_prdata  <= '0;
                            if (r_write && (r_dec == DEC_RW)) begin
                                for (int i = 0; i < NUM_REGS; i++) begin
                                    if (r_idx == IDX_W'(i)) begin
                                        r_regs[i]     <= apply_strb(r_regs[i], r_wdata, r_strb);
                                        r_wr_pulse[i] <= 1'b1;
                                    end
                                end
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= (r_dec == DEC_ERR);
                            r_prdata  <= r_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[32*g +: 32] = r_regs[g];
    end

    assign pready      = r_pready;
    assign pslverr     = r_pslverr;
    assign prdata      = r_prdata;
    assign wr_pulse    = r_wr_pulse;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_apb_reg_responder.sv
// Bench for apb_reg_responder: a zero-wait and a three-wait instance share one APB bus;
// a reference model predicts each completion and monitors compare as responses appear.
`timescale 1ns/1ps
module tb_apb_reg_responder;
    localparam int NREG    = 8;
    localparam int W       = 32 * NREG;
    localparam int WS_SLOW = 3;

    typedef struct {
        logic [31:0]     rdata;
        logic            err;
        logic [NREG-1:0] pulse;
        logic [W-1:0]    regs;
        int              cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [31:0] status_i;

    logic            pready_v   [2];
    logic            pslverr_v  [2];
    logic [31:0]     prdata_v   [2];
    logic [W-1:0]    reg_q_v    [2];
    logic [NREG-1:0] wr_pulse_v [2];
    logic            dbg_v      [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl [NREG];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_reg_responder #(.NUM_REGS(NREG), .WAIT_STATES(0), .STATUS_ADDR(12'h100)) u_dut_fast (
        .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .pready(pready_v[0]),
        .pslverr(pslverr_v[0]), .prdata(prdata_v[0]), .reg_q(reg_q_v[0]),
        .wr_pulse(wr_pulse_v[0]), .status_i(status_i), .o_dbg_state(dbg_v[0])
    );

    apb_reg_responder #(.NUM_REGS(NREG), .WAIT_STATES(WS_SLOW), .STATUS_ADDR(12'h100)) u_dut_slow (
        .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .pready(pready_v[1]),
        .pslverr(pslverr_v[1]), .prdata(prdata_v[1]), .reg_q(reg_q_v[1]),
        .wr_pulse(wr_pulse_v[1]), .status_i(status_i), .o_dbg_state(dbg_v[1])
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [11:0] a, input logic w, input logic [3:0] s,
                                   input logic [31:0] d);
        exp_t e;
        int   word;
        e.rdata = '0;
        e.err   = 1'b0;
        e.pulse = '0;
        e.cyc   = 0;
        word    = int'(a) / 4;
        if (a == 12'h100) begin
            if (w) e.err = 1'b1;
            else   e.rdata = status_i;
        end else if ((int'(a) % 4) != 0 || word >= NREG) begin
            e.err = 1'b1;
        end else if (w) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) mdl[word][8*k +: 8] = d[8*k +: 8];
            end
            e.pulse[word] = 1'b1;
        end else begin
            e.rdata = mdl[word];
        end
        for (int i = 0; i < NREG; i++) e.regs[32*i +: 32] = mdl[i];
        return e;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = 12'($urandom());
        pwdata  = $urandom();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [11:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        exp_t it;
        int   k;
        logic done;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pstrb = s; pwdata = d;
        @(posedge clk); #1;
        it = model(a, w, s, d);
        it.cyc = cyc;
        q0.push_back(it);
        it.cyc = cyc + WS_SLOW;
        q1.push_back(it);
        penable = 1'b1;
        k = 0;
        done = 1'b0;
        while (!done && k <= 30) begin
            @(negedge clk);
            if (pready_v[1]) done = 1'b1;
            k++;
        end
        check("xfer_done", W'(done), W'(1));
        @(posedge clk); #1;
    endtask

    task automatic abort_xfer(input logic [11:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pstrb = 4'hF; pwdata = d;
        @(posedge clk); #1;
        check("abort_in_access_fast", W'(dbg_v[0]), W'(1));
        check("abort_in_access_slow", W'(dbg_v[1]), W'(1));
        psel = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_fast", W'(dbg_v[0]), W'(0));
        check("abort_idle_slow", W'(dbg_v[1]), W'(0));
        idle(1);
    endtask

    task automatic reset_mid_xfer(input logic [11:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pstrb = 4'hF; pwdata = d;
        @(posedge clk); #1;
        check("rst_in_access_slow", W'(dbg_v[1]), W'(1));
        penable = 1'b1;
        reset_n = 1'b0;
        mdl_reset();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
    endtask

    // ---------------- monitors / scoreboard ----------------
    for (genvar d = 0; d < 2; d++) begin : g_mon
        logic [W-1:0]    cur_regs   = '0;
        logic [W-1:0]    pend_regs  = '0;
        logic            pend_valid = 1'b0;
        logic [NREG-1:0] next_pulse = '0;
        logic            ok;
        exp_t            it;
        always @(negedge clk) begin
            if (!reset_n) begin
                cur_regs   = '0;
                pend_valid = 1'b0;
                next_pulse = '0;
                check($sformatf("rst_pready_d%0d", d), W'(pready_v[d]), W'(0));
                check($sformatf("rst_pslverr_d%0d", d), W'(pslverr_v[d]), W'(0));
                check($sformatf("rst_prdata_d%0d", d), W'(prdata_v[d]), W'(0));
                check($sformatf("rst_reg_q_d%0d", d), reg_q_v[d], W'(0));
                check($sformatf("rst_wr_pulse_d%0d", d), W'(wr_pulse_v[d]), W'(0));
            end else begin
                if (pend_valid) begin
                    cur_regs   = pend_regs;
                    pend_valid = 1'b0;
                end
                check($sformatf("reg_q_d%0d", d), reg_q_v[d], cur_regs);
                check($sformatf("wr_pulse_d%0d", d), W'(wr_pulse_v[d]), W'(next_pulse));
                next_pulse = '0;
                if (pready_v[d] && psel && penable) begin
                    if (d == 0) begin
                        ok = (q0.size() > 0);
                        if (ok) it = q0.pop_front();
                    end else begin
                        ok = (q1.size() > 0);
                        if (ok) it = q1.pop_front();
                    end
                    check($sformatf("expected_pending_d%0d", d), W'(ok), W'(1));
                    if (ok) begin
                        check($sformatf("pready_cycle_d%0d", d), W'(cyc), W'(it.cyc));
                        check($sformatf("prdata_d%0d", d), W'(prdata_v[d]), W'(it.rdata));
                        check($sformatf("pslverr_d%0d", d), W'(pslverr_v[d]), W'(it.err));
                        pend_regs  = it.regs;
                        pend_valid = 1'b1;
                        next_pulse = it.pulse;
                    end
                end else if (!pready_v[d]) begin
                    check($sformatf("idle_prdata_d%0d", d), W'(prdata_v[d]), W'(0));
                    check($sformatf("idle_pslverr_d%0d", d), W'(pslverr_v[d]), W'(0));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] a;
        int          kind;
        reset_n  = 1'b0;
        status_i = '0;
        mdl_reset();
        for (int i = 0; i < 6; i++) begin
            psel    = 1'($urandom_range(0, 1));
            penable = 1'($urandom_range(0, 1));
            pwrite  = 1'($urandom_range(0, 1));
            paddr   = 12'($urandom());
            pstrb   = 4'($urandom());
            pwdata  = $urandom();
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        idle(2);

        xfer(12'h004, 1'b1, 4'hF, 32'hDEADBEEF);
        check("reg1_after_write", W'(reg_q_v[0][63:32]), W'(32'hDEADBEEF));
        check("wr_pulse_reg1_slow", W'(wr_pulse_v[1]), W'(8'h02));
        idle(1);
        xfer(12'h004, 1'b0, 4'h0, 32'h0);

        xfer(12'h000, 1'b1, 4'hF, 32'hAABBCCDD);
        xfer(12'h000, 1'b1, 4'b0101, 32'h11223344);
        check("reg0_partial", W'(reg_q_v[1][31:0]), W'(32'hAA22CC44));
        xfer(12'h000, 1'b0, 4'h0, 32'h0);
        idle(1);

        xfer(12'h002, 1'b0, 4'h0, 32'h0);
        xfer(12'h020, 1'b0, 4'h0, 32'h0);
        xfer(12'h100, 1'b1, 4'hF, 32'h12345678);
        status_i = 32'h0000_00A5;
        xfer(12'h100, 1'b0, 4'h0, 32'h0);
        xfer(12'h008, 1'b1, 4'h0, 32'hFFFFFFFF);
        idle(2);

        xfer(12'h00C, 1'b1, 4'hF, 32'hCAFEF00D);
        xfer(12'h00C, 1'b0, 4'h0, 32'h0);
        idle(1);
        abort_xfer(12'h00C, 32'h0BADBEEF);
        xfer(12'h00C, 1'b0, 4'h0, 32'h0);

        xfer(12'h014, 1'b1, 4'hF, 32'h55AA55AA);
        reset_mid_xfer(12'h014, 32'h12345678);
        check("reg_q_after_reset_slow", reg_q_v[1], W'(0));
        xfer(12'h014, 1'b0, 4'h0, 32'h0);

        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)      a = 12'(4 * $urandom_range(0, NREG - 1));
            else if (kind == 6) a = 12'(4 * $urandom_range(0, NREG - 1) + $urandom_range(1, 3));
            else if (kind == 7) a = 12'(32 + 4 * $urandom_range(0, 50));
            else if (kind == 8) a = 12'h100;
            else                a = 12'($urandom());
            status_i = $urandom();
            xfer(a, 1'($urandom_range(0, 1)), 4'($urandom()), $urandom());
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        idle(4);
        check("q_fast_drained", W'(q0.size()), W'(0));
        check("q_slow_drained", W'(q1.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_reg_responder.md
# apb_reg_responder

APB completer (responder) terminating the bus driven by the APB VIP master/driver, providing a bank of software-writable control registers plus one hardware read-only status register. Sits between the APB bus and the UART core configuration/status signals; also serves as the reference DUT for bring-up of the APB VIP. Supports byte strobes, a fixed number of inserted wait states, and error response on illegal accesses.

## Interface
- NUM_REGS, 8, number of 32-bit RW registers, at byte addresses 0x000 + 4*i (1..64)
- WAIT_STATES, 0, extra access-phase cycles before pready (0..15)
- STATUS_ADDR, 12'h100, byte address of the read-only status register
---
- clk  in  1  bus clock
- reset_n  in  1  asynchronous active-low reset
- psel  in  1  select
- penable  in  1  access phase
- pwrite  in  1  1 = write
- paddr  in  12  byte address
- pstrb  in  4  write byte strobes
- pwdata  in  32  write data
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid only with pready
- prdata  out  32  read data, valid only with pready on reads
- reg_q  out  32*NUM_REGS  RW register contents, reg i at bits [32*i +: 32]
- wr_pulse  out  NUM_REGS  one-cycle strobe, reg i updated
- status_i  in  32  hardware status, read at STATUS_ADDR

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: pready=0. On psel=1 & penable=0 at a clk edge: latch paddr, pwrite, pstrb, pwdata; decode; load wait counter cnt <= WAIT_STATES; capture read data into prdata register; go to ACCESS.
- ACCESS: pready = (cnt==0), driven from registers only (no input-to-output path). While cnt!=0, cnt decrements each cycle.
- Completion: edge with state=ACCESS, cnt==0, psel=1, penable=1 → commit (write if legal), go IDLE.
- psel=0 while in ACCESS (protocol violation): abort, no write, go IDLE, pready=0 next cycle.
- Decode: legal RW if paddr[1:0]==0 and paddr/4 < NUM_REGS; legal RO if paddr==STATUS_ADDR and pwrite=0.
- Error (pslverr=1 with pready): misaligned address, unmapped address, write to STATUS_ADDR. Errored writes modify nothing; errored reads return prdata=0.
- Write: byte lane k of reg updated from pwdata[8k+:8] iff pstrb[k]; pstrb=0 is legal, no change, wr_pulse still fires.
- Read: prdata = selected register or status_i sampled at setup edge; prdata=0 during writes and whenever pready=0.
- Reset values: all reg_q 0, prdata 0, pready 0, pslverr 0, wr_pulse 0, state IDLE, cnt 0. Reset assertion mid-transfer returns to IDLE immediately; no partial write.

## Timing
- Zero-wait transfer: setup cycle + 1 access cycle (pready high in first access cycle).
- Transfer with WAIT_STATES=N: pready rises N cycles after first access cycle; total N+2 cycles.
- reg_q and wr_pulse update on the completion edge (visible the cycle after pready=1); wr_pulse high exactly one cycle.
- Back-to-back: new setup accepted in the cycle immediately after completion (IDLE state); no idle cycle required.
- pslverr, prdata stable and meaningful only while pready=1; both 0 otherwise.

## Structure
- Shared package apb_pkg: APB_ADDR_W=12, APB_DATA_W=32, APB_STRB_W=4, FSM state enum (IDLE, ACCESS), decode-result enum (DEC_RW, DEC_RO, DEC_ERR).
- One sub-module natural: apb_addr_decode (combinational: paddr, pwrite → decode result, register index).

## Test plan
- Reset: hold reset_n=0 with random inputs → pready=0, pslverr=0, prdata=0, all reg_q=0.
- Write 0xDEADBEEF to 0x004, pstrb=4'hF, WAIT_STATES=0 → pready in cycle 2, pslverr=0, reg_q[63:32]=0xDEADBEEF, wr_pulse=8'h02 for one cycle; read back 0x004 → prdata=0xDEADBEEF.
- Partial write pstrb=4'b0101 data 0x11223344 to 0x000 holding 0xAABBCCDD → reg 0 = 0xAA22CC44.
- Errors: read 0x002, read 0x020 (NUM_REGS=8), write 0x100 → pslverr=1 with pready, prdata=0, no reg_q change, no wr_pulse.
- Status read: status_i=0x0000_00A5, read 0x100 → prdata=0xA5, pslverr=0.
- WAIT_STATES=3: back-to-back write then read → pready after 3 wait cycles each, second setup accepted right after first completion; psel dropped mid-ACCESS → no write, FSM to IDLE; reset_n pulsed mid-ACCESS → register unchanged.
